// File: rtl/frame_mode_scheduler.sv
// Frame-synchronous processing-option select for the image processor: round-robin manual
// mode requests applied only at frame boundaries, plus an optional auto-cycle through enabled modes.
module frame_mode_scheduler #(
  parameter int                        NUM_REQ      = 4,
  parameter int                        MODE_W       = 3,
  parameter int                        CYCLE_FRAMES = 60,
  parameter logic [(1<<MODE_W)-1:0]    AUTO_MASK    = 8'h7F
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iLineValid,
  input  logic [NUM_REQ-1:0]           iReq,
  input  logic [NUM_REQ*MODE_W-1:0]    iReqMode,
  input  logic                         iAuto,
  output logic [NUM_REQ-1:0]           oGnt,
  output logic [MODE_W-1:0]            oMode,
  output logic                         oPending,
  output logic                         oSwitch,
  output logic [15:0]                  oFrameCnt
);

  localparam int NUM_MODES = 1 << MODE_W;
  localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W     = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLE_FRAMES - 1);

  typedef enum logic {sIdle, sPend} stateT;

  stateT             state;
  logic              lineValidQ;
  logic [PTR_W-1:0]  rrPtr;
  logic [CNT_W-1:0]  cycleCnt;
  logic [MODE_W-1:0] latchedMode;

  logic              frameEdge;
  logic              reqHit;
  logic [PTR_W-1:0]  reqIdx;
  logic [PTR_W-1:0]  reqCand;
  logic              autoFound;
  logic [MODE_W-1:0] autoNext;
  logic [MODE_W-1:0] modeCand;

  // Falling edge of frame-valid; lineValidQ resets low so release never fakes an edge.
  assign frameEdge = lineValidQ & ~iLineValid;

  // Round-robin scan: first asserted request at or above the pointer, wrapping.
  // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    reqHit  = 1'b0;
    reqIdx  = '0;
    reqCand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqCand = PTR_W'((int'(rrPtr) + i) % NUM_REQ);
      if (!reqHit && iReq[reqCand]) begin
        reqHit = 1'b1;
        reqIdx = reqCand;
      end
    end
  end

  // Next enabled mode strictly after the current one, wrapping through zero.
  always_comb begin
    autoFound = 1'b0;
    autoNext  = oMode;
    modeCand  = oMode;
    for (int i = 1; i < NUM_MODES; i++) begin
      modeCand = oMode + MODE_W'(i);
      if (!autoFound && AUTO_MASK[modeCand]) begin
        autoFound = 1'b1;
        autoNext  = modeCand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state       <= sIdle;
      lineValidQ  <= 1'b0;
      rrPtr       <= '0;
      cycleCnt    <= '0;
      latchedMode <= '0;
      oGnt        <= '0;
      oMode       <= '0;
      oPending    <= 1'b0;
      oSwitch     <= 1'b0;
      oFrameCnt   <= '0;
    end else begin
      lineValidQ <= iLineValid;
      oGnt       <= '0;
      oSwitch    <= 1'b0;
      if (frameEdge)
        oFrameCnt <= oFrameCnt + 16'd1;

      case (state)
        sIdle: begin
          if (reqHit) begin
            // A grant coinciding with a boundary still waits for the following one.
            oGnt        <= NUM_REQ'(1) << reqIdx;
            latchedMode <= iReqMode[int'(reqIdx)*MODE_W +: MODE_W];
            rrPtr       <= (reqIdx == LAST_REQ) ? '0 : reqIdx + 1'b1;
            oPending    <= 1'b1;
            state       <= sPend;
          end else if (frameEdge && iAuto) begin
            if (cycleCnt == LAST_CNT) begin
              cycleCnt <= '0;
              if (autoFound) begin
                oMode   <= autoNext;
                oSwitch <= 1'b1;
              end
            end else begin
              cycleCnt <= cycleCnt + 1'b1;
            end
          end
        end
        sPend: begin
          if (frameEdge) begin
            oMode    <= latchedMode;
            oSwitch  <= 1'b1;
            cycleCnt <= '0;
            oPending <= 1'b0;
            state    <= sIdle;
          end
        end
        default: state <= sIdle;
      endcase

      // Last assignment wins: with auto-cycle off the counter is parked at zero.
      if (!iAuto)
        cycleCnt <= '0;
    end
  end

endmodule

// File: tb/tb_frame_mode_scheduler.sv
// Bench for frame_mode_scheduler: directed scenarios against fixed expectations, then
// random traffic against a frame-level reference model of the arbitration and mode rules.
module tb_frame_mode_scheduler;

  localparam int              NR = 4;
  localparam int              MW = 3;
  localparam int              CF = 2;
  localparam logic [7:0]      AM = 8'h05;

  logic              iClk = 1'b0;
  logic              iRst = 1'b0;
  logic              iLineValid = 1'b0;
  logic [NR-1:0]     iReq = '0;
  logic [NR*MW-1:0]  iReqMode = '0;
  logic              iAuto = 1'b0;
  logic [NR-1:0]     oGnt;
  logic [MW-1:0]     oMode;
  logic              oPending;
  logic              oSwitch;
  logic [15:0]       oFrameCnt;

  int nCompared = 0;
  int nMismatch = 0;

  // Reference model state (advanced once per clock by modelStep)
  logic [MW-1:0] mMode, mLatched;
  logic [NR-1:0] mGnt;
  logic          mPend, mSwitch, mLv;
  logic [15:0]   mFrames;
  int            mPtr, mFramesSinceSwitch;

  frame_mode_scheduler #(
    .NUM_REQ(NR), .MODE_W(MW), .CYCLE_FRAMES(CF), .AUTO_MASK(AM)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iLineValid(iLineValid), .iReq(iReq),
    .iReqMode(iReqMode), .iAuto(iAuto), .oGnt(oGnt), .oMode(oMode),
    .oPending(oPending), .oSwitch(oSwitch), .oFrameCnt(oFrameCnt)
  );

  always #5 iClk = ~iClk;

  task automatic cycle();
    @(negedge iClk);
  endtask

  // One full frame: valid high for a cycle, then low; returns just after the boundary edge.
  task automatic frame();
    iLineValid = 1'b1;
    @(negedge iClk);
    iLineValid = 1'b0;
    @(negedge iClk);
  endtask

  task automatic doReset();
    iRst = 1'b0; iReq = '0; iReqMode = '0; iAuto = 1'b0; iLineValid = 1'b0;
    repeat (2) @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
  endtask

  task automatic setReq(input int k, input logic [MW-1:0] mode);
    iReq[k] = 1'b1;
    iReqMode[k*MW +: MW] = mode;
  endtask

  function automatic logic [MW-1:0] nextEnabled(input logic [MW-1:0] cur);
    for (int d = 1; d < (1 << MW); d++) begin
      if (AM[(int'(cur) + d) % (1 << MW)]) return MW'((int'(cur) + d) % (1 << MW));
    end
    return cur;
  endfunction

  task automatic modelReset();
    mMode = '0; mLatched = '0; mGnt = '0; mPend = 1'b0; mSwitch = 1'b0;
    mLv = 1'b0; mFrames = '0; mPtr = 0; mFramesSinceSwitch = 0;
  endtask

  // Applies the scheduling rules to the inputs that the coming clock edge will sample.
  task automatic modelStep();
    logic boundary;
    int   winner;
    boundary = mLv && !iLineValid;
    winner   = -1;
    mGnt     = '0;
    mSwitch  = 1'b0;
    if (boundary) mFrames = mFrames + 16'd1;
    if (!mPend) begin
      for (int i = 0; i < NR; i++)
        if (winner < 0 && iReq[(mPtr + i) % NR]) winner = (mPtr + i) % NR;
    end
    if (winner >= 0) begin
      mGnt[winner] = 1'b1;
      mLatched     = iReqMode[winner*MW +: MW];
      mPtr         = (winner + 1) % NR;
      mPend        = 1'b1;
    end else if (mPend && boundary) begin
      mMode = mLatched; mSwitch = 1'b1; mPend = 1'b0; mFramesSinceSwitch = 0;
    end else if (boundary && iAuto) begin
      mFramesSinceSwitch++;
      if (mFramesSinceSwitch == CF) begin
        mFramesSinceSwitch = 0;
        if (nextEnabled(mMode) != mMode) begin
          mMode   = nextEnabled(mMode);
          mSwitch = 1'b1;
        end
      end
    end
    if (!iAuto) mFramesSinceSwitch = 0;
    mLv = iLineValid;
  endtask

  task automatic test_reset();
    iReq = 4'hF; iLineValid = 1'b1;
    cycle();
    nCompared++;
    if ({oGnt, oMode, oPending, oSwitch, oFrameCnt} !== '0) begin
      nMismatch++;
      $display("FAIL reset_hold: gnt=%b mode=%0d pend=%b sw=%b frames=%0d, want all zero",
               oGnt, oMode, oPending, oSwitch, oFrameCnt);
    end
    iLineValid = 1'b0;
    cycle();
    nCompared++;
    if ({oGnt, oMode, oPending, oSwitch, oFrameCnt} !== '0) begin
      nMismatch++;
      $display("FAIL reset_edge: gnt=%b mode=%0d pend=%b sw=%b frames=%0d, want all zero",
               oGnt, oMode, oPending, oSwitch, oFrameCnt);
    end
    doReset();
  endtask

  task automatic test_single_request();
    setReq(2, 3'd5);
    cycle();
    nCompared++;
    if ({oGnt, oPending, oMode, oSwitch} !== {4'b0100, 1'b1, 3'd0, 1'b0}) begin
      nMismatch++;
      $display("FAIL single_grant: gnt=%b pend=%b mode=%0d sw=%b, want 0100 1 0 0", oGnt, oPending, oMode, oSwitch);
    end
    iReq[2] = 1'b0;
    cycle();
    nCompared++;
    if ({oGnt, oPending} !== {4'b0000, 1'b1}) begin
      nMismatch++;
      $display("FAIL single_pulse: gnt=%b pend=%b, want 0000 1", oGnt, oPending);
    end
    frame();
    nCompared++;
    if ({oMode, oSwitch, oPending, oFrameCnt} !== {3'd5, 1'b1, 1'b0, 16'd1}) begin
      nMismatch++;
      $display("FAIL single_apply: mode=%0d sw=%b pend=%b frames=%0d, want 5 1 0 1", oMode, oSwitch, oPending, oFrameCnt);
    end
    cycle();
    nCompared++;
    if ({oMode, oSwitch} !== {3'd5, 1'b0}) begin
      nMismatch++;
      $display("FAIL single_after: mode=%0d sw=%b, want 5 0", oMode, oSwitch);
    end
  endtask

  task automatic test_round_robin();
    doReset();
    setReq(0, 3'd3);
    setReq(3, 3'd6);
    cycle();
    nCompared++;
    if (oGnt !== 4'b0001) begin
      nMismatch++;
      $display("FAIL rr_first: gnt=%b, want 0001", oGnt);
    end
    iReq[0] = 1'b0;
    frame();
    nCompared++;
    if ({oMode, oSwitch, oGnt} !== {3'd3, 1'b1, 4'b0000}) begin
      nMismatch++;
      $display("FAIL rr_apply0: mode=%0d sw=%b gnt=%b, want 3 1 0000", oMode, oSwitch, oGnt);
    end
    cycle();
    nCompared++;
    if ({oGnt, oPending, oMode} !== {4'b1000, 1'b1, 3'd3}) begin
      nMismatch++;
      $display("FAIL rr_second: gnt=%b pend=%b mode=%0d, want 1000 1 3", oGnt, oPending, oMode);
    end
    iReq[3] = 1'b0;
    frame();
    nCompared++;
    if ({oMode, oSwitch} !== {3'd6, 1'b1}) begin
      nMismatch++;
      $display("FAIL rr_apply3: mode=%0d sw=%b, want 6 1", oMode, oSwitch);
    end
    setReq(0, 3'd1);
    setReq(1, 3'd2);
    cycle();
    nCompared++;
    if (oGnt !== 4'b0001) begin
      nMismatch++;
      $display("FAIL rr_wrap: gnt=%b, want 0001 (pointer back at 0)", oGnt);
    end
    iReq = '0;
    frame();
    nCompared++;
    if (oMode !== 3'd1) begin
      nMismatch++;
      $display("FAIL rr_apply_wrap: mode=%0d, want 1", oMode);
    end
  endtask

  task automatic test_grant_on_boundary();
    logic [15:0] framesBefore;
    framesBefore = oFrameCnt;
    iLineValid = 1'b1;
    cycle();
    iLineValid = 1'b0;
    setReq(1, 3'd6);
    cycle();
    nCompared++;
    if ({oGnt, oMode, oSwitch, oPending, oFrameCnt} !== {4'b0010, 3'd1, 1'b0, 1'b1, framesBefore + 16'd1}) begin
      nMismatch++;
      $display("FAIL same_edge: gnt=%b mode=%0d sw=%b pend=%b frames=%0d, want 0010 1 0 1 %0d",
               oGnt, oMode, oSwitch, oPending, oFrameCnt, framesBefore + 16'd1);
    end
    iReq[1] = 1'b0;
    frame();
    nCompared++;
    if ({oMode, oSwitch, oPending} !== {3'd6, 1'b1, 1'b0}) begin
      nMismatch++;
      $display("FAIL same_edge_next: mode=%0d sw=%b pend=%b, want 6 1 0", oMode, oSwitch, oPending);
    end
  endtask

  task automatic test_auto_cycle();
    logic [MW-1:0] expMode [7] = '{3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 3'd2, 3'd2};
    logic          expSw   [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    doReset();
    iAuto = 1'b1;
    for (int f = 0; f < 7; f++) begin
      frame();
      nCompared++;
      if ({oMode, oSwitch} !== {expMode[f], expSw[f]}) begin
        nMismatch++;
        $display("FAIL auto_frame%0d: mode=%0d sw=%b, want %0d %b", f + 1, oMode, oSwitch, expMode[f], expSw[f]);
      end
    end
    setReq(0, 3'd7);
    cycle();
    iReq[0] = 1'b0;
    frame();
    nCompared++;
    if ({oMode, oSwitch} !== {3'd7, 1'b1}) begin
      nMismatch++;
      $display("FAIL auto_override: mode=%0d sw=%b, want 7 1", oMode, oSwitch);
    end
    frame();
    nCompared++;
    if ({oMode, oSwitch} !== {3'd7, 1'b0}) begin
      nMismatch++;
      $display("FAIL auto_restart: mode=%0d sw=%b, want 7 0", oMode, oSwitch);
    end
    frame();
    nCompared++;
    if ({oMode, oSwitch} !== {3'd0, 1'b1}) begin
      nMismatch++;
      $display("FAIL auto_wrap: mode=%0d sw=%b, want 0 1", oMode, oSwitch);
    end
    iAuto = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    doReset();
    setReq(1, 3'd3);
    cycle();
    iReq[1] = 1'b0;
    frame();
    setReq(2, 3'd4);
    cycle();
    iReq[2] = 1'b0;
    iLineValid = 1'b1;
    cycle();
    #2 iRst = 1'b0;
    #1;
    nCompared++;
    if ({oGnt, oMode, oPending, oSwitch, oFrameCnt} !== '0) begin
      nMismatch++;
      $display("FAIL midreset_async: gnt=%b mode=%0d pend=%b sw=%b frames=%0d, want all zero",
               oGnt, oMode, oPending, oSwitch, oFrameCnt);
    end
    iLineValid = 1'b0;
    @(negedge iClk);
    iRst = 1'b1;
    repeat (3) cycle();
    nCompared++;
    if ({oMode, oPending, oSwitch, oFrameCnt} !== '0) begin
      nMismatch++;
      $display("FAIL midreset_noedge: mode=%0d pend=%b sw=%b frames=%0d, want all zero",
               oMode, oPending, oSwitch, oFrameCnt);
    end
    frame();
    nCompared++;
    if ({oMode, oSwitch, oFrameCnt} !== {3'd0, 1'b0, 16'd1}) begin
      nMismatch++;
      $display("FAIL midreset_first: mode=%0d sw=%b frames=%0d, want 0 0 1", oMode, oSwitch, oFrameCnt);
    end
  endtask

  task automatic test_frame_count();
    doReset();
    setReq(3, 3'd5);
    cycle();
    iReq[3] = 1'b0;
    for (int f = 0; f < 3000; f++) frame();
    nCompared++;
    if ({oFrameCnt, oMode, oPending} !== {16'd3000, 3'd5, 1'b0}) begin
      nMismatch++;
      $display("FAIL frame_count: frames=%0d mode=%0d pend=%b, want 3000 5 0", oFrameCnt, oMode, oPending);
    end
  endtask

  task automatic test_random();
    int lvLeft;
    lvLeft = 0;
    doReset();
    modelReset();
    for (int c = 0; c < 16000; c++) begin
      for (int k = 0; k < NR; k++) begin
        if (oGnt[k]) iReq[k] = 1'b0;
        else if (!iReq[k] && $urandom_range(0, 7) == 0) setReq(k, MW'($urandom));
        else if (iReq[k] && $urandom_range(0, 63) == 0) iReq[k] = 1'b0;
      end
      if (lvLeft == 0) begin
        iLineValid = ~iLineValid;
        lvLeft = int'($urandom_range(1, 5));
      end else begin
        lvLeft--;
      end
      if (c % 700 == 0) iAuto = 1'($urandom_range(0, 1));
      modelStep();
      @(negedge iClk);
      nCompared++;
      if ({oGnt, oMode, oPending, oSwitch, oFrameCnt} !== {mGnt, mMode, mPend, mSwitch, mFrames}) begin
        nMismatch++;
        $display("FAIL random_c%0d: gnt=%b mode=%0d pend=%b sw=%b frames=%0d, model gnt=%b mode=%0d pend=%b sw=%b frames=%0d",
                 c, oGnt, oMode, oPending, oSwitch, oFrameCnt, mGnt, mMode, mPend, mSwitch, mFrames);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_grant_on_boundary();
    test_auto_cycle();
    test_reset_mid_frame();
    test_frame_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
